// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, divisor width and the baud divisor function.
package spi_pkg;

    localparam int DIV_W = 12;

    typedef enum logic [1:0] {
        SPI_RUN  = 2'b00,
        SPI_WAIT = 2'b01,
        SPI_STOP = 2'b10
    } spi_mode_e;

    // Baud divisor = (sppr+1) * 2^(spr+1); spans 2..2048.
    function automatic logic [DIV_W-1:0] calc_divisor(input logic [2:0] sppr,
                                                      input logic [2:0] spr);
        logic [DIV_W-1:0] base_v;
        base_v = {{(DIV_W-3){1'b0}}, sppr} + {{(DIV_W-1){1'b0}}, 1'b1};
        return base_v << ({1'b0, spr} + 4'd1);
    endfunction

endpackage

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: half-period counter toggling sclk, with one-pclk
// sample/drive strobes aligned to each sclk edge.
module spi_baud_generator
    import spi_pkg::*;
(
    input  logic             pclk,
    input  logic             preset,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             ss,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    output logic             sclk,
    output logic             miso_recieve_sclk,
    output logic             miso_recieve_sclk0,
    output logic             mosi_send_sclk,
    output logic             mosi_send_sclk0,
    output logic [DIV_W-1:0] baud_rate_divisor
);

    logic [DIV_W-1:0] divisor_s;
    logic [DIV_W-1:0] half_s;
    logic             mode_ok_s;
    logic             enable_s;
    logic             terminal_s;
    logic             same_phase_s;

    logic [DIV_W-1:0] count_r;
    logic [DIV_W-1:0] count_nx_s;
    logic             sclk_r;
    logic             sclk_nx_s;
    // Strobe bit order: {miso_recieve_sclk, miso_recieve_sclk0, mosi_send_sclk, mosi_send_sclk0}
    logic [3:0]       strobe_r;
    logic [3:0]       strobe_nx_s;

    assign divisor_s         = calc_divisor(sppr, spr);
    assign half_s            = divisor_s >> 1;
    assign baud_rate_divisor = divisor_s;

    // Decode whether the current mode lets sclk run.
    always_comb begin
        mode_ok_s = 1'b0;
        case (spi_mode)
            SPI_RUN:  mode_ok_s = 1'b1;
            SPI_WAIT: mode_ok_s = ~spiswai;
            default:  mode_ok_s = 1'b0;
        endcase
    end

    assign enable_s     = ~ss & mode_ok_s;
    // >= keeps a shrinking divisor from letting the counter run past the terminal value.
    assign terminal_s   = (count_r >= (half_s - {{(DIV_W-1){1'b0}}, 1'b1}));
    assign same_phase_s = (cpha == cpol);

    // Next-state for counter, sclk level and edge strobes.
    always_comb begin
        count_nx_s  = count_r;
        sclk_nx_s   = sclk_r;
        strobe_nx_s = 4'b0000;
        if (!enable_s) begin
            count_nx_s = {DIV_W{1'b0}};
            sclk_nx_s  = cpol;
        end else if (terminal_s) begin
            count_nx_s = {DIV_W{1'b0}};
            sclk_nx_s  = ~sclk_r;
            if (!sclk_r) begin
                if (same_phase_s) begin
                    strobe_nx_s = 4'b1000;
                end else begin
                    strobe_nx_s = 4'b0001;
                end
            end else begin
                if (same_phase_s) begin
                    strobe_nx_s = 4'b0010;
                end else begin
                    strobe_nx_s = 4'b0100;
                end
            end
        end else begin
            count_nx_s = count_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // State register; reset parks sclk at its idle polarity.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count_r  <= {DIV_W{1'b0}};
            sclk_r   <= cpol;
            strobe_r <= 4'b0000;
        end else begin
            count_r  <= count_nx_s;
            sclk_r   <= sclk_nx_s;
            strobe_r <= strobe_nx_s;
        end
    end

    assign sclk               = sclk_r;
    assign miso_recieve_sclk  = strobe_r[3];
    assign miso_recieve_sclk0 = strobe_r[2];
    assign mosi_send_sclk     = strobe_r[1];
    assign mosi_send_sclk0    = strobe_r[0];

endmodule

// File: tb/tb_spi_baud_generator.sv
// Self-checking bench for spi_baud_generator: cycle model plus directed timing pins and random stimulus.
module tb_spi_baud_generator;

    logic        pclk;
    logic        preset;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic        ss;
    logic        cpol;
    logic        cpha;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        sclk;
    logic        miso_recieve_sclk;
    logic        miso_recieve_sclk0;
    logic        mosi_send_sclk;
    logic        mosi_send_sclk0;
    logic [11:0] baud_rate_divisor;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    spi_baud_generator dut (
        .pclk               (pclk),
        .preset             (preset),
        .spi_mode           (spi_mode),
        .spiswai            (spiswai),
        .ss                 (ss),
        .cpol               (cpol),
        .cpha               (cpha),
        .sppr               (sppr),
        .spr                (spr),
        .sclk               (sclk),
        .miso_recieve_sclk  (miso_recieve_sclk),
        .miso_recieve_sclk0 (miso_recieve_sclk0),
        .mosi_send_sclk     (mosi_send_sclk),
        .mosi_send_sclk0    (mosi_send_sclk0),
        .baud_rate_divisor  (baud_rate_divisor)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: tracks elapsed enabled cycles since the last sclk edge.
    bit       m_sclk;
    bit [3:0] m_str;     // {miso_r, miso_r0, mosi_s, mosi_s0}
    int       m_elapsed;

    always @(posedge pclk or posedge preset) begin
        bit       en;
        int       half;
        int       el;
        bit       nsclk;
        bit [3:0] nstr;
        if (preset) begin
            m_sclk    <= cpol;
            m_str     <= 4'b0000;
            m_elapsed <= 0;
        end else begin
            en    = !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
            half  = (int'(sppr) + 1) * (1 << (int'(spr) + 1)) / 2;
            nstr  = 4'b0000;
            nsclk = m_sclk;
            el    = 0;
            if (!en) begin
                nsclk = cpol;
            end else begin
                el = m_elapsed + 1;
                if (el >= half) begin
                    nsclk = !m_sclk;
                    el    = 0;
                    if (nsclk) nstr = (cpha == cpol) ? 4'b1000 : 4'b0001;
                    else       nstr = (cpha == cpol) ? 4'b0010 : 4'b0100;
                end
            end
            m_sclk    <= nsclk;
            m_str     <= nstr;
            m_elapsed <= el;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge pclk) begin
        #1;
        if (chk_en) begin
            check("sclk", int'(sclk), int'(m_sclk));
            check("miso_recieve_sclk",  int'(miso_recieve_sclk),  int'(m_str[3]));
            check("miso_recieve_sclk0", int'(miso_recieve_sclk0), int'(m_str[2]));
            check("mosi_send_sclk",     int'(mosi_send_sclk),     int'(m_str[1]));
            check("mosi_send_sclk0",    int'(mosi_send_sclk0),    int'(m_str[0]));
            check("divisor", int'(baud_rate_divisor), (int'(sppr) + 1) * (1 << (int'(spr) + 1)));
            check("strobe_onehot",
                  int'(miso_recieve_sclk) + int'(miso_recieve_sclk0) + int'(mosi_send_sclk) + int'(mosi_send_sclk0) <= 1,
                  1);
        end
    end

    // Counts posedges until sclk changes level; bounded by max_cyc.
    task automatic wait_toggle(input int max_cyc, output int n);
        logic prev;
        prev = sclk;
        n = 0;
        while (n < max_cyc) begin
            @(posedge pclk);
            #1;
            n++;
            if (sclk !== prev) return;
        end
        check("toggle_timeout", n, -1);
    endtask

    initial begin
        int n;
        preset   = 1'b1;
        spi_mode = 2'b00;
        spiswai  = 1'b0;
        ss       = 1'b1;
        cpol     = 1'b1;
        cpha     = 1'b0;
        sppr     = 3'd1;
        spr      = 3'd1;
        chk_en   = 1'b1;

        // Reset state with cpol=1.
        repeat (3) @(posedge pclk);
        #1;
        check("reset_sclk", int'(sclk), 1);
        check("reset_strobes", int'({miso_recieve_sclk, miso_recieve_sclk0, mosi_send_sclk, mosi_send_sclk0}), 0);
        check("reset_divisor", int'(baud_rate_divisor), 8);
        @(negedge pclk);
        preset = 1'b0;
        cpol   = 1'b0;
        @(posedge pclk);
        #1;
        check("idle_sclk_cpol0", int'(sclk), 0);

        // Mode 0: half=4, 16 edges.
        @(negedge pclk);
        ss = 1'b0;
        wait_toggle(20, n);
        check("mode0_first_edge", n, 4);
        check("mode0_first_edge_miso", int'(miso_recieve_sclk), 1);
        for (int i = 0; i < 15; i++) begin
            wait_toggle(20, n);
            check("mode0_half_period", n, 4);
        end

        // Mode 1: divide by 2.
        @(negedge pclk);
        ss   = 1'b1;
        sppr = 3'd0;
        spr  = 3'd0;
        cpha = 1'b1;
        #1;
        check("mode1_divisor", int'(baud_rate_divisor), 2);
        @(negedge pclk);
        ss = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_toggle(5, n);
            check("mode1_half_period", n, 1);
        end

        // WAIT with spiswai holds sclk; release gives a full half period.
        @(negedge pclk);
        ss       = 1'b1;
        cpha     = 1'b0;
        sppr     = 3'd1;
        spr      = 3'd0;
        spi_mode = 2'b01;
        spiswai  = 1'b1;
        @(negedge pclk);
        ss = 1'b0;
        repeat (10) @(posedge pclk);
        #1;
        check("wait_hold_sclk", int'(sclk), 0);
        @(negedge pclk);
        spiswai = 1'b0;
        wait_toggle(10, n);
        check("wait_release_edge", n, 2);

        // Abort while sclk high, then restart.
        @(negedge pclk);
        ss = 1'b1;
        @(posedge pclk);
        #1;
        check("abort_sclk", int'(sclk), 0);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        ss = 1'b0;
        wait_toggle(10, n);
        check("restart_edge", n, 2);

        // Divisor shrink mid-period: count 5 with half 8, then half 4.
        @(negedge pclk);
        ss       = 1'b1;
        spi_mode = 2'b00;
        sppr     = 3'd3;
        spr      = 3'd1;
        @(negedge pclk);
        ss = 1'b0;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        sppr = 3'd1;
        @(posedge pclk);
        #1;
        check("shrink_no_wrap", int'(sclk), 1);

        // Maximum divisor.
        @(negedge pclk);
        ss   = 1'b1;
        sppr = 3'd7;
        spr  = 3'd7;
        #1;
        check("max_divisor", int'(baud_rate_divisor), 2048);
        @(negedge pclk);
        ss = 1'b0;
        wait_toggle(1100, n);
        check("max_first_edge", n, 1024);
        wait_toggle(1100, n);
        check("max_half_period", n, 1024);

        // Random stimulus against the model.
        @(negedge pclk);
        sppr = 3'd1;
        spr  = 3'd0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge pclk);
            if (preset) preset = 1'b0;
            if ($urandom_range(0, 39) == 0)  ss = ~ss;
            if ($urandom_range(0, 59) == 0)  spi_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)  spiswai = ~spiswai;
            if ($urandom_range(0, 29) == 0) begin
                sppr = 3'($urandom_range(0, 7));
                spr  = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 199) == 0) cpol = ~cpol;
            if ($urandom_range(0, 199) == 0) cpha = ~cpha;
            if ($urandom_range(0, 499) == 0) preset = 1'b1;
        end
        @(negedge pclk);
        preset = 1'b0;
        repeat (2) @(posedge pclk);
        #2;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
